// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction fetch stage ahead of decode.
// Issues word fetches over a req/gnt/rvalid bus, buffers the returned
// instructions with their PCs in a prefetch FIFO and presents them to decode
// over a valid/ready handshake. A redirect flushes the FIFO, restarts fetch at
// the new PC and drops every response that is still in flight.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   imem_req/addr/gnt           fetch request channel (addr word aligned)
//   imem_rvalid/rdata           in-order fetch response channel
//   redirect_valid/pc           flush and restart fetch at redirect_pc
//   if_valid/ready/pc/instr     instruction handshake towards decode
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [OUT_W-1:0] out_cnt;
  logic [OUT_W-1:0] discard_cnt;
  logic [OUT_W-1:0] out_cnt_nxt;

  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        grant;
  logic        accept;
  logic        pop;
  logic [31:0] redirect_tgt;

  // Credit check: every granted request must have a FIFO slot waiting for it,
  // so in-flight plus buffered entries never exceed the FIFO depth.
  assign imem_req = !rst && !redirect_valid
                    && (32'(out_cnt) < MAX_OUTSTANDING)
                    && ((32'(out_cnt) + 32'(count)) < FIFO_DEPTH);
  assign imem_addr = fetch_pc;

  assign grant        = imem_req && imem_gnt;
  assign accept       = imem_rvalid && !redirect_valid && (discard_cnt == '0);
  assign pop          = if_valid && if_ready;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign out_cnt_nxt  = out_cnt + OUT_W'(grant) - OUT_W'(imem_rvalid);

  // Head of the FIFO is presented straight from storage; no rdata bypass.
  assign if_valid = (count != '0);
  assign if_pc    = fifo_pc[rd_ptr];
  assign if_instr = fifo_instr[rd_ptr];

  // Fetch/response PCs, credit counters and prefetch FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      out_cnt     <= '0;
      discard_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      out_cnt <= out_cnt_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc    <= redirect_tgt;
        resp_pc     <= redirect_tgt;
        discard_cnt <= out_cnt_nxt;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_rvalid && (discard_cnt != '0)) begin
          discard_cnt <= discard_cnt - OUT_W'(1);
        end
        if (accept) begin
          fifo_pc[wr_ptr]    <= resp_pc;
          fifo_instr[wr_ptr] <= imem_rdata;
          wr_ptr             <= wr_ptr + PTR_W'(1);
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(accept) - CNT_W'(pop);
      end
    end
  end

  // Bus protocol and FIFO capacity checks.
  always @(posedge clk) begin
    if (!rst) begin
      a_rvalid_has_credit: assert (!(imem_rvalid && (out_cnt == '0)));
      a_no_overflow: assert (!(accept && !pop && (32'(count) == FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Testbench for riscv_fetch_unit: in-order memory model plus a queue-based
// reference of the instruction stream decode must observe.
module tb_riscv_fetch_unit;

  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MAXOUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  riscv_fetch_unit #(
    .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          live;
  } req_t;

  typedef struct {
    int unsigned lat;
    int unsigned hold;
    logic [31:0] tgt;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } redir_vec_t;

  int unsigned checks = 0;
  int unsigned failures = 0;

  req_t        mq[$];      // granted, not yet returned requests
  logic [31:0] fq[$];      // PCs decode should currently see, head first
  logic [31:0] popped[$];  // PCs accepted by decode
  logic [31:0] exp_fetch;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned lat_max = 1;
  int unsigned gnt_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned redir_pct = 0;
  bit          redir_now = 0;
  logic [31:0] redir_tgt = '0;
  int unsigned dut_grants = 0;
  int          first_grant = -1;
  int          first_valid = -1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check and update the model
  // on the falling edge, then advance past the next rising edge.
  task automatic tick();
    bit          exp_req, grant, pop;
    req_t        ent;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if_ready = ($urandom_range(99) < rdy_pct);
    if (!redir_now && redir_pct != 0 && $urandom_range(99) < redir_pct) begin
      redir_now = 1'b1;
      redir_tgt = $urandom;
    end
    redirect_valid = redir_now;
    redirect_pc    = redir_tgt;
    redir_now      = 1'b0;
    @(negedge clk);

    exp_req = !redirect_valid && (mq.size() < MAXOUT) && (mq.size() + fq.size() < DEPTH);
    chk(imem_req == exp_req, "imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk(imem_addr == exp_fetch, "imem_addr", imem_addr, exp_fetch);
    chk(if_valid == (fq.size() != 0), "if_valid", 32'(if_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk(if_pc == fq[0], "if_pc", if_pc, fq[0]);
      chk(if_instr == mem(fq[0]), "if_instr", if_instr, mem(fq[0]));
    end
    if (if_valid && first_valid < 0) first_valid = int'(cyc);
    if (imem_req && imem_gnt) dut_grants++;

    grant = exp_req && imem_gnt;
    pop   = (fq.size() != 0) && if_ready;
    if (pop) begin
      popped.push_back(fq[0]);
      void'(fq.pop_front());
    end
    if (imem_rvalid) begin
      ent = mq.pop_front();
      if (ent.live && !redirect_valid) fq.push_back(ent.addr);
    end
    if (grant) begin
      if (first_grant < 0) first_grant = int'(cyc);
      mq.push_back('{addr: exp_fetch, due: cyc + lat, live: 1'b1});
      exp_fetch = exp_fetch + 32'd4;
      if (lat_max > 1) lat = $urandom_range(lat_max, 1);
    end
    if (redirect_valid) begin
      fq.delete();
      foreach (mq[i]) mq[i].live = 1'b0;
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    #1;
    chk(if_valid == 1'b0, "rst_if_valid", 32'(if_valid), 32'h0);
    chk(imem_req == 1'b0, "rst_imem_req", 32'(imem_req), 32'h0);
    chk(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
    chk(if_instr == 32'h0, "rst_if_instr", if_instr, 32'h0);
    mq.delete();
    fq.delete();
    popped.delete();
    exp_fetch   = RPC;
    dut_grants  = 0;
    first_grant = -1;
    first_valid = -1;
    redir_now   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  redir_vec_t vecs[4];

  initial begin
    vecs[0] = '{lat: 3, hold: 6,  tgt: 32'h0000_0103, exp0: 32'h0000_0100, exp1: 32'h0000_0104};
    vecs[1] = '{lat: 1, hold: 3,  tgt: 32'h0000_0200, exp0: 32'h0000_0200, exp1: 32'h0000_0204};
    vecs[2] = '{lat: 2, hold: 0,  tgt: 32'hFFFF_FFFE, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
    vecs[3] = '{lat: 4, hold: 10, tgt: 32'h0000_0001, exp0: 32'h0000_0000, exp1: 32'h0000_0004};

    // Streaming with single-cycle memory and decode always ready.
    do_reset();
    lat = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
    for (int k = 0; k < 30; k++) tick();
    chk(first_valid - first_grant == 2, "first_latency",
        32'(first_valid - first_grant), 32'd2);
    chk(popped.size() >= 8, "stream_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk(popped[i] == 32'(4 * i), "stream_pc", popped[i], 32'(4 * i));

    // Decode stalled: exactly FIFO_DEPTH fetches, then ordered drain.
    do_reset();
    rdy_pct = 0;
    for (int k = 0; k < 20; k++) tick();
    chk(dut_grants == DEPTH, "stall_grants", 32'(dut_grants), 32'(DEPTH));
    chk(imem_req == 1'b0, "stall_req_low", 32'(imem_req), 32'h0);
    rdy_pct = 100;
    for (int k = 0; k < 10; k++) tick();
    chk(popped.size() >= 4, "drain_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk(popped[i] == 32'(4 * i), "drain_pc", popped[i], 32'(4 * i));

    // Slow memory with random grants: credit limit and address hold.
    do_reset();
    lat = 3; gnt_pct = 50; rdy_pct = 100;
    for (int k = 0; k < 200; k++) tick();
    chk(popped.size() > 10, "slow_progress", 32'(popped.size()), 32'd11);

    // Redirect vectors: build in-flight/FIFO state, redirect, check restart.
    foreach (vecs[v]) begin
      do_reset();
      lat = vecs[v].lat; gnt_pct = 100; rdy_pct = 0;
      for (int k = 0; k < int'(vecs[v].hold); k++) tick();
      redir_now = 1'b1; redir_tgt = vecs[v].tgt;
      tick();
      chk(if_valid == 1'b0, "redir_if_valid", 32'(if_valid), 32'h0);
      popped.delete();
      rdy_pct = 100;
      for (int k = 0; k < 40 && popped.size() < 2; k++) tick();
      chk(popped.size() >= 2, "redir_timeout", 32'(popped.size()), 32'd2);
      if (popped.size() >= 2) begin
        chk(popped[0] == vecs[v].exp0, "redir_pc0", popped[0], vecs[v].exp0);
        chk(popped[1] == vecs[v].exp1, "redir_pc1", popped[1], vecs[v].exp1);
      end
    end

    // Redirect coinciding with rvalid, then a second redirect next cycle.
    do_reset();
    lat = 1; gnt_pct = 100; rdy_pct = 100;
    for (int k = 0; k < 5; k++) tick();
    for (int k = 0; k < 10 && !(mq.size() > 0 && mq[0].due <= cyc); k++) tick();
    chk(mq.size() > 0 && mq[0].due <= cyc, "b2b_setup", 32'(mq.size()), 32'd1);
    redir_now = 1'b1; redir_tgt = 32'h0000_0500;
    tick();
    redir_now = 1'b1; redir_tgt = 32'h0000_0200;
    tick();
    popped.delete();
    for (int k = 0; k < 20 && popped.size() < 1; k++) tick();
    chk(popped.size() >= 1, "b2b_timeout", 32'(popped.size()), 32'd1);
    if (popped.size() >= 1) chk(popped[0] == 32'h200, "b2b_pc", popped[0], 32'h200);

    // Reset with requests outstanding and a partly filled FIFO.
    do_reset();
    lat = 3; gnt_pct = 100; rdy_pct = 0;
    for (int k = 0; k < 40 && !(mq.size() == 2 && fq.size() == 2); k++) tick();
    chk(mq.size() == 2 && fq.size() == 2, "midrst_setup",
        32'(mq.size() * 16 + fq.size()), 32'h22);
    do_reset();
    lat = 1; rdy_pct = 100;
    for (int k = 0; k < 10; k++) tick();
    chk(popped.size() >= 1, "midrst_restart", 32'(popped.size()), 32'd1);
    if (popped.size() >= 1) chk(popped[0] == RPC, "midrst_pc", popped[0], RPC);

    // Random traffic with random latency, stalls and redirects.
    do_reset();
    lat = 1; lat_max = 4; gnt_pct = 70; rdy_pct = 60; redir_pct = 3;
    for (int k = 0; k < 3000; k++) tick();
    redir_pct = 0;
    chk(popped.size() > 100, "rand_progress", 32'(popped.size()), 32'd101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
